sr_fetch: RTL and testbench

//  Instruction fetch stage for schoolRISCV: owns the fetch PC, issues word reads to instruction

---
 rtl/sr_fetch_pkg.sv | 12 +
 rtl/sr_fetch_fifo.sv | 71 +++++++
 rtl/sr_fetch.sv | 105 ++++++++++
 tb/tb_sr_fetch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_fetch_pkg.sv
// Shared types and constants for the schoolRISCV fetch stage.
package sr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sr_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch_entry_t with flush.
// Latency: a push is visible at the head the cycle after it is written; no bypass.
// Backpressure: none internally; the producer must not push when full unless popping.
module sr_fetch_fifo
  import sr_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    count    = count_q;
    head_dat = mem_q[rd_ptr_q];
    // Flush beats push; a pop frees the slot a same-cycle push into a full FIFO needs.
    do_pop   = pop && !empty && !flush;
    do_push  = push && (!full || do_pop) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/sr_fetch.sv
// Fetch stage: owns fetch PC, issues imem reads under credit, buffers words for decode.
// Latency: response at cycle N appears on instr_vld at N+1; 1 instr/cycle sustained.
// Backpressure: instr_rdy low fills the buffer, after which credit stops new requests.
module sr_fetch
  import sr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_vld,
  input  logic        imem_req_rdy,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_vld,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_vld,
  input  logic        instr_rdy,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] out_after_rsp;
  logic [CW:0]   credit_used;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_dat;
  logic          req_fire;
  logic          rsp_keep;
  logic          pop;

  sr_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rsp_keep),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect_vld),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    // Every in-flight request already owns a buffer slot, so responses never overflow.
    credit_used   = {1'b0, fifo_count} + {1'b0, out_q};
    imem_req_vld  = rst_n && !redirect_vld && (credit_used < (CW+1)'(FIFO_DEPTH));
    imem_req_addr = fetch_pc_q;
    req_fire      = imem_req_vld && imem_req_rdy;

    rsp_keep       = imem_rsp_vld && (drop_q == '0) && !redirect_vld;
    push_dat.pc    = resp_pc_q;
    push_dat.instr = imem_rsp_data;

    instr_vld = !fifo_empty;
    instr     = fifo_empty ? NOP_INSTR : fifo_head.instr;
    instr_pc  = fifo_empty ? 32'h0 : fifo_head.pc;
    pop       = instr_vld && instr_rdy;

    out_after_rsp = out_q - CW'(imem_rsp_vld);
    out_d         = out_after_rsp + CW'(req_fire);

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    if (redirect_vld) begin
      // Everything still in flight after this cycle is stale, including earlier drops.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = out_after_rsp;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_keep) resp_pc_d  = resp_pc_q + 32'd4;
      if (imem_rsp_vld && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  a_drop_le_out: assert property (@(posedge clk) disable iff (!rst_n) drop_q <= out_q);
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_vld && (out_q == '0)));

endmodule

// File: tb/tb_sr_fetch.sv
// Bench for sr_fetch: memory model plus scoreboard of expected {pc, word} per accepted request.
module tb_sr_fetch;
  import sr_fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        imem_req_vld;
  logic        imem_req_rdy;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_vld;
  logic [31:0] imem_rsp_data;
  logic        instr_vld;
  logic        instr_rdy;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  sr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_vld  (redirect_vld),
    .redirect_pc   (redirect_pc),
    .imem_req_vld  (imem_req_vld),
    .imem_req_rdy  (imem_req_rdy),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_vld  (imem_rsp_vld),
    .imem_rsp_data (imem_rsp_data),
    .instr_vld     (instr_vld),
    .instr_rdy     (instr_rdy),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          pops = 0;
  int          first_acc = -1;
  int          first_vld = -1;
  int          last_due = 0;
  int          lat_fix = 1;
  bit          lat_rnd = 1'b0;
  logic [31:0] model_pc = RST_PC;
  logic [31:0] tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory: returns queued reads in order once their due cycle arrives.
  initial begin
    imem_rsp_vld  = 1'b0;
    imem_rsp_data = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        pend_q.delete();
        imem_rsp_vld = 1'b0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rsp_vld  = 1'b1;
        imem_rsp_data = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rsp_vld  = 1'b0;
        imem_rsp_data = $urandom;
      end
    end
  end

  // Monitor: records accepted requests as expectations and checks every delivered instruction.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_vld", 32'(imem_req_vld), 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_instr_vld", 32'(instr_vld), 32'd0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_instr_pc", instr_pc, 32'h0);
        exp_q.delete();
        pend_q.delete();
        model_pc  = RST_PC;
        acc_cnt   = 0;
        first_acc = -1;
        first_vld = -1;
        last_due  = 0;
      end else if (redirect_vld) begin
        chk("redir_no_req", 32'(imem_req_vld), 32'd0);
        exp_q.delete();
        model_pc = redirect_pc;
      end else begin
        if (instr_vld && first_vld < 0) first_vld = cyc;
        if (imem_req_vld && imem_req_rdy) begin
          exp_t  e;
          pend_t p;
          int    lat;
          chk("req_addr", imem_req_addr, model_pc);
          e.pc  = model_pc;
          e.ins = mem_word(model_pc);
          exp_q.push_back(e);
          lat    = lat_fix + (lat_rnd ? int'($urandom_range(0, 3)) : 0);
          p.addr = imem_req_addr;
          p.due  = cyc + lat;
          if (p.due <= last_due) p.due = last_due + 1;
          last_due = p.due;
          pend_q.push_back(p);
          if (first_acc < 0) first_acc = cyc;
          acc_cnt++;
          model_pc = model_pc + 32'd4;
        end
        if (instr_vld && instr_rdy) begin
          pops++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got pc %h, want no instruction", instr_pc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", instr, e.ins);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int p0;
    int n;
    rst_n        = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;
    imem_req_rdy = 1'b1;
    instr_rdy    = 1'b1;

    // Streaming with single-cycle memory
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("first_vld_lat", 32'(first_vld - first_acc), 32'd2);
    p0 = pops;
    repeat (10) tick();
    chk("throughput", 32'(pops - p0), 32'd10);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("rst_imm_req_vld", 32'(imem_req_vld), 32'd0);
    chk("rst_imm_instr_vld", 32'(instr_vld), 32'd0);
    chk("rst_imm_instr", instr, NOP_INSTR);

    // Decode stalled: credit must stop at buffer depth
    instr_rdy = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("credit_acc", 32'(acc_cnt), 32'(DEPTH));
    chk("credit_req_vld", 32'(imem_req_vld), 32'd0);
    chk("full_instr_vld", 32'(instr_vld), 32'd1);
    chk("full_head_pc", instr_pc, RST_PC);
    instr_rdy = 1'b1;
    repeat (20) tick();

    // Redirect with two reads in flight on a 3-cycle memory
    rst_n   = 1'b0;
    lat_fix = 3;
    repeat (3) tick();
    rst_n = 1'b1;
    n = 0;
    while (acc_cnt < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("redir_setup", 32'(acc_cnt), 32'd2);
    imem_req_rdy = 1'b0;
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0000_0100;
    tick();
    redirect_vld = 1'b0;
    imem_req_rdy = 1'b1;
    n = 0;
    while (!instr_vld && n < 30) begin
      tick();
      n++;
    end
    chk("redir_wait", 32'(instr_vld), 32'd1);
    chk("redir_first_pc", instr_pc, 32'h0000_0100);
    chk("redir_first_instr", instr, mem_word(32'h0000_0100));
    repeat (10) tick();

    // Redirect coinciding with a response and a pop
    lat_fix = 1;
    repeat (10) tick();
    chk("coinc_setup", 32'({imem_rsp_vld, instr_vld}), 32'd3);
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0000_0200;
    tick();
    redirect_vld = 1'b0;
    chk("coinc_flushed", 32'(instr_vld), 32'd0);
    n = 0;
    while (!instr_vld && n < 30) begin
      tick();
      n++;
    end
    chk("coinc_first_pc", instr_pc, 32'h0000_0200);
    repeat (10) tick();

    // Random backpressure, latency and redirects, with one reset in the middle
    lat_rnd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      imem_req_rdy = ($urandom_range(0, 3) != 0);
      instr_rdy    = ($urandom_range(0, 2) != 0);
      redirect_vld = ($urandom_range(0, 39) == 0);
      if (redirect_vld) begin
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt[31:6] = '1;
        tgt[1:0] = 2'b00;
        redirect_pc = tgt;
      end
      if (i == 1500) begin
        redirect_vld = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
      end
      tick();
    end
    redirect_vld = 1'b0;
    imem_req_rdy = 1'b1;
    instr_rdy    = 1'b1;
    repeat (30) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
